multicycle_control: RTL

- Sequential successor to the single-cycle RV32I instruction decoder.
- Sequences each instruction through FETCH → DECODE → EXEC → (MEM) → WB, with req/ack handshakes to instruction and data memory.
- Generates the registered datapath control bundle and sign-extended immediate, and resolves branches.
- Adds LUI/AUIPC, rd=x0 write suppression, memory timeout and a sticky illegal-instruction trap.

---
 rtl/multicycle_control_if.sv | 11 +
 rtl/multicycle_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Instruction- and data-memory handshake bundle for the multicycle control sequencer.
interface multicycle_control_if;
  logic        instReq;
  logic        instAck;
  logic [31:0] inst;
  logic        memReq;
  logic        memAck;

  modport master (output instReq, memReq, input instAck, inst, memAck);
  modport slave  (input instReq, memReq, output instAck, inst, memAck);
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control sequencer: fetch/decode/exec/mem/wb with registered control bundle.
//
// state  | meaning
// FETCH  | instReq high, wait for instAck, latch instruction
// DECODE | register control bundle, trap on illegal encoding
// EXEC   | resolve branch, route to MEM or WB
// MEM    | memReq high, wait for memAck or timeout
// WB     | pcWriteEn / regsWriteEn strobe
// TRAP   | sticky illegal, all strobes low until reset
module multicycle_control #(
  parameter int IMM_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int EN_UPPER    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_if.master     bus,
  input  logic                     eq,
  input  logic                     lt,
  output logic                     dataASel,
  output logic                     dataBSel,
  output logic                     pcSel,
  output logic                     pcWriteEn,
  output logic                     regsWriteEn,
  output logic [1:0]               writeDataSel,
  output logic [3:0]               aluMode,
  output logic [3:0]               ramMode,
  output logic [IMM_W-1:0]         immOut,
  output logic                     illegal,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

  state_t             state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [31:0]        inst_q;
  logic               instReq_q, memReq_q, pcWriteEn_q, regsWriteEn_q, illegal_q;
  logic               asel_q, bsel_q, pcsel_q, wr_q, mem_q, br_q;
  logic [1:0]         wsel_q;
  logic [3:0]         alu_q, ram_q;
  logic [IMM_W-1:0]   imm_q;

  logic               asel_d, bsel_d, pcsel_d, wr_d, mem_d, br_d, bad_d, taken;
  logic [1:0]         wsel_d;
  logic [3:0]         alu_d, ram_d;
  logic [IMM_W-1:0]   imm_d;

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic signed [11:0] i_imm, s_imm;
  logic signed [12:0] b_imm;
  logic signed [20:0] j_imm;
  logic signed [31:0] u_imm;

  assign opc   = inst_q[6:0];
  assign f3    = inst_q[14:12];
  assign i_imm = inst_q[31:20];
  assign s_imm = {inst_q[31:25], inst_q[11:7]};
  assign b_imm = {inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign j_imm = {inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
  assign u_imm = {inst_q[31:12], 12'b0};

  always_comb begin
    asel_d = 1'b0;
    bsel_d = 1'b0;
    pcsel_d = 1'b0;
    wsel_d = 2'b00;
    alu_d  = 4'b0000;
    ram_d  = 4'b0000;
    imm_d  = '0;
    wr_d   = 1'b0;
    mem_d  = 1'b0;
    br_d   = 1'b0;
    bad_d  = 1'b0;
    case (opc)
      7'b0110011: begin
        alu_d = {f3, inst_q[30]};
        wr_d  = 1'b1;
      end
      7'b0010011: begin
        bsel_d = 1'b1;
        imm_d  = IMM_W'(i_imm);
        alu_d  = {f3, (f3 == 3'b101) ? inst_q[30] : 1'b0};
        wr_d   = 1'b1;
      end
      7'b0000011: begin
        bsel_d = 1'b1;
        imm_d  = IMM_W'(i_imm);
        wsel_d = 2'b01;
        ram_d  = {f3, 1'b0};
        wr_d   = 1'b1;
        mem_d  = 1'b1;
      end
      7'b0100011: begin
        bsel_d = 1'b1;
        imm_d  = IMM_W'(s_imm);
        ram_d  = {f3, 1'b1};
        mem_d  = 1'b1;
      end
      7'b1100011: begin
        asel_d = 1'b1;
        bsel_d = 1'b1;
        imm_d  = IMM_W'(b_imm);
        br_d   = 1'b1;
        bad_d  = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b1100111: begin
        bsel_d  = 1'b1;
        imm_d   = IMM_W'(i_imm);
        pcsel_d = 1'b1;
        wsel_d  = 2'b10;
        wr_d    = 1'b1;
      end
      7'b1101111: begin
        asel_d  = 1'b1;
        bsel_d  = 1'b1;
        imm_d   = IMM_W'(j_imm);
        pcsel_d = 1'b1;
        wsel_d  = 2'b10;
        wr_d    = 1'b1;
      end
      7'b0110111: begin
        imm_d  = IMM_W'(u_imm);
        wsel_d = 2'b11;
        wr_d   = 1'b1;
        bad_d  = (EN_UPPER == 0);
      end
      7'b0010111: begin
        asel_d = 1'b1;
        bsel_d = 1'b1;
        imm_d  = IMM_W'(u_imm);
        wr_d   = 1'b1;
        bad_d  = (EN_UPPER == 0);
      end
      default: bad_d = 1'b1;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:          taken = eq;
      3'b001:          taken = ~eq;
      3'b100, 3'b110:  taken = lt;
      3'b101, 3'b111:  taken = ~lt;
      default:         taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      FETCH:  if (instReq_q && bus.instAck) state_d = DECODE;
      DECODE: state_d = bad_d ? TRAP : EXEC;
      EXEC: begin
        state_d = mem_q ? MEM : WB;
        tmr_d   = TMR_LOAD;
      end
      MEM: begin
        // ack wins over an expiring timer in the same cycle
        if (memReq_q && bus.memAck) begin
          state_d = WB;
        end else if (MEM_TIMEOUT > 0) begin
          if (tmr_q == '0) state_d = TRAP;
          else             tmr_d   = tmr_q - 1'b1;
        end
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Strobes are registered decodes of the next state so they are low throughout reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      tmr_q         <= '0;
      inst_q        <= '0;
      instReq_q     <= 1'b0;
      memReq_q      <= 1'b0;
      pcWriteEn_q   <= 1'b0;
      regsWriteEn_q <= 1'b0;
      illegal_q     <= 1'b0;
      asel_q        <= 1'b0;
      bsel_q        <= 1'b0;
      pcsel_q       <= 1'b0;
      wr_q          <= 1'b0;
      mem_q         <= 1'b0;
      br_q          <= 1'b0;
      wsel_q        <= 2'b00;
      alu_q         <= 4'b0000;
      ram_q         <= 4'b0000;
      imm_q         <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      instReq_q     <= (state_d == FETCH);
      memReq_q      <= (state_d == MEM);
      pcWriteEn_q   <= (state_d == WB);
      regsWriteEn_q <= (state_d == WB) && wr_q && (inst_q[11:7] != 5'd0);
      illegal_q     <= (state_d == TRAP);
      if (state_q == FETCH && instReq_q && bus.instAck) inst_q <= bus.inst;
      if (state_q == DECODE && !bad_d) begin
        asel_q  <= asel_d;
        bsel_q  <= bsel_d;
        pcsel_q <= pcsel_d;
        wr_q    <= wr_d;
        mem_q   <= mem_d;
        br_q    <= br_d;
        wsel_q  <= wsel_d;
        alu_q   <= alu_d;
        ram_q   <= ram_d;
        imm_q   <= imm_d;
      end
      if (state_q == EXEC && br_q) pcsel_q <= taken;
    end
  end

  assign bus.instReq  = instReq_q;
  assign bus.memReq   = memReq_q;
  assign dataASel     = asel_q;
  assign dataBSel     = bsel_q;
  assign pcSel        = pcsel_q;
  assign pcWriteEn    = pcWriteEn_q;
  assign regsWriteEn  = regsWriteEn_q;
  assign writeDataSel = wsel_q;
  assign aluMode      = alu_q;
  assign ramMode      = ram_q;
  assign immOut       = imm_q;
  assign illegal      = illegal_q;
  assign state        = state_q;

endmodule
